// File: rtl/uart_prog_loader.sv
// Boot loader: packs UART bytes into little-endian 32-bit words and writes them to
// consecutive instruction-memory addresses, holding the core in reset until END_WORD arrives.
module uart_prog_loader #(
  parameter int          ADDR_W   = 13,
  parameter logic [31:0] END_WORD = 32'h0000_0FFF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_byte_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              core_rst_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_cnt_o
);

  typedef enum logic [1:0] {LOAD, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_nxt;
  logic [1:0]        idx;
  logic [23:0]       asm_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   cnt_q;
  logic              err_q;

  logic              take;
  logic              complete;
  logic [31:0]       word;
  logic              is_end;
  logic              is_full;

  // Only the lower three lanes need storage; the top lane is the byte arriving with the completing strobe.
  assign take     = rx_valid_i && (state != DONE);
  assign complete = take && (idx == 2'd3);
  assign word     = {rx_byte_i, asm_q};
  assign is_end   = (word == END_WORD);
  assign is_full  = (cnt_q == CAPACITY);

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD, WRITE: begin
        if (complete) begin
          if (is_end || is_full) state_nxt = DONE;
          else                   state_nxt = WRITE;
        end else if (state == WRITE) begin
          state_nxt = LOAD;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= LOAD;
      idx          <= 2'd0;
      asm_q        <= 24'd0;
      addr_q       <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= 32'd0;
    end else begin
      state <= state_nxt;
      if (take) begin
        idx <= idx + 2'd1;
        if (idx != 2'd3) asm_q[{idx, 3'b000} +: 8] <= rx_byte_i;
      end
      if (complete && !is_end) begin
        if (is_full) begin
          err_q <= 1'b1;
        end else begin
          imem_wdata_o <= word;
          imem_addr_o  <= addr_q;
        end
      end
      if (state == WRITE) begin
        addr_q <= addr_q + ADDR_W'(1);
        cnt_q  <= cnt_q + (ADDR_W + 1)'(1);
      end
    end
  end

  assign imem_we_o  = (state == WRITE);
  assign done_o     = (state == DONE) && !err_q;
  assign err_o      = err_q;
  assign core_rst_o = !done_o;
  assign word_cnt_o = cnt_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Randomized scoreboard bench for uart_prog_loader: a byte-list reference model predicts
// memory writes (checked by an independent monitor) and status flags.
module tb_uart_prog_loader;

  localparam int          ADDR_W   = 3;
  localparam logic [31:0] END_WORD = 32'h0000_0FFF;
  localparam int          CAP      = 1 << ADDR_W;

  logic              clock;
  logic              reset;
  logic              rx_valid_i;
  logic [7:0]        rx_byte_i;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_wdata_o;
  logic              core_rst_o;
  logic              done_o;
  logic              err_o;
  logic [ADDR_W:0]   word_cnt_o;

  uart_prog_loader #(.ADDR_W(ADDR_W), .END_WORD(END_WORD)) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_valid_i   (rx_valid_i),
    .rx_byte_i    (rx_byte_i),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .core_rst_o   (core_rst_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .word_cnt_o   (word_cnt_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int unsigned cyc;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  m_bytes[$];
  int          m_cnt;
  bit          m_done;
  bit          m_err;
  int          m_last_addr;
  logic [31:0] m_last_data;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write-enable cycle must match the oldest predicted write, in the predicted cycle.
  always @(negedge clock) begin
    if (imem_we_o !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write", imem_addr_o, imem_wdata_o);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (imem_we_o !== 1'b1 || int'(imem_addr_o) != e.addr || imem_wdata_o !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL write: got addr %0d data %h cyc %0d, expected addr %0d data %h cyc %0d",
                   imem_addr_o, imem_wdata_o, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  // Reference model: bytes of the current word are queued; a full queue forms one word.
  task automatic model_byte(input logic [7:0] b);
    logic [31:0] w;
    wr_t e;
    if (m_done || m_err) return;
    m_bytes.push_back(b);
    if (m_bytes.size() == 4) begin
      w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
      m_bytes.delete();
      if (w == END_WORD) m_done = 1'b1;
      else if (m_cnt == CAP) m_err = 1'b1;
      else begin
        e.addr = m_cnt;
        e.data = w;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        m_last_addr = m_cnt;
        m_last_data = w;
        m_cnt++;
      end
    end
  endtask

  task automatic model_reset();
    m_bytes.delete();
    m_cnt       = 0;
    m_done      = 1'b0;
    m_err       = 1'b0;
    m_last_addr = 0;
    m_last_data = 32'd0;
  endtask

  // Entered and left on a negedge; gap 0 gives back-to-back strobes.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid_i = 1'b1;
    rx_byte_i  = b;
    model_byte(b);
    @(negedge clock);
    rx_valid_i = 1'b0;
    chk("done_timing", {31'd0, done_o}, {31'd0, m_done});
    chk("err_timing", {31'd0, err_o}, {31'd0, m_err});
    chk("core_rst_timing", {31'd0, core_rst_o}, {31'd0, !m_done});
    repeat (gap) @(negedge clock);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic send_rand_word(input int maxgap);
    logic [31:0] w;
    w = $urandom;
    if (w == END_WORD) w = w ^ 32'h1;
    send_word(w, $urandom_range(0, maxgap));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic settle_and_check(input string tag);
    repeat (3) @(negedge clock);
    chk({tag, "_done"}, {31'd0, done_o}, {31'd0, m_done});
    chk({tag, "_err"}, {31'd0, err_o}, {31'd0, m_err});
    chk({tag, "_core_rst"}, {31'd0, core_rst_o}, {31'd0, !m_done});
    chk({tag, "_word_cnt"}, 32'(word_cnt_o), 32'(m_cnt));
    chk({tag, "_addr_hold"}, 32'(imem_addr_o), 32'(m_last_addr));
    chk({tag, "_wdata_hold"}, imem_wdata_o, m_last_data);
    chk({tag, "_we_idle"}, {31'd0, imem_we_o}, 32'd0);
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    rx_valid_i = 1'b0;
    rx_byte_i  = 8'd0;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    settle_and_check("reset");

    // Simple load
    send_word(32'h1234_5678, 1);
    send_word(32'hDEAD_BEEF, 1);
    send_word(END_WORD, 1);
    settle_and_check("simple");

    // Back-to-back strobes
    do_reset();
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 0);
    send_word(END_WORD, 0);
    settle_and_check("b2b");

    // Immediate END
    do_reset();
    send_word(END_WORD, 0);
    settle_and_check("imm_end");

    // Reset mid-word
    do_reset();
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 1);
    do_reset();
    send_word(32'h4433_2211, 0);
    send_word(END_WORD, 0);
    settle_and_check("rst_mid");

    // DONE ignores further input
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), $urandom_range(0, 1));
    settle_and_check("done_ignore");

    // Randomized loads
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int k = 0; k < int'($urandom_range(0, CAP)); k++) send_rand_word(2);
      send_word(END_WORD, $urandom_range(0, 1));
      settle_and_check("rand");
    end

    // Overflow: one word beyond capacity, then trailing bytes ignored
    do_reset();
    for (int k = 0; k < CAP + 1; k++) send_rand_word(1);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
    send_word(END_WORD, 0);
    settle_and_check("overflow");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
